glitch_seq_wb: RTL and testbench

- Parametrised successor to the single-shot Wishbone glitcher.
- Holds a programmable table of up to DEPTH glitch entries. Each entry has its own mode, delay and width.
- Plays the table back in order, optionally repeated, driving clk_out from clk_in/clk_gl.
- Sits on the 8-bit Wishbone register bus next to the existing glitch peripherals. All counting is in clk_i cycles.

---
 rtl/glitch_seq_wb.sv | 274 +++++++++++++++++++++++++++
 tb/tb_glitch_seq_wb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_seq_wb.sv
// glitch_seq_wb: table-driven clock glitch sequencer on the 8-bit Wishbone register bus.
// Holds up to DEPTH {mode, delay, width} entries and plays them back in order, optionally
// repeated, swapping clk_out away from clk_in while an entry is in its WIDTH phase.
// All counting is in clk_i cycles.
//
// Optional feature: define GLITCH_SEQ_TRIG_EN to add trig_i and an ARMED state. With it,
// start arms the sequencer and the first synchronised rising edge of trig_i launches
// playback; STATUS bit4 reports armed.
//
// Ports:
//   clk_i, rst_i      system clock, asynchronous active-low reset
//   dat_i/adr_i       write data, word address (adr[5:2])
//   stb_i/we_i        strobe, write enable
//   dat_o/ack_o       registered read data, registered acknowledge
//   clk_in/clk_gl     target clock and alternate glitch clock
//   trig_i            external trigger (GLITCH_SEQ_TRIG_EN only)
//   clk_out           glitched clock (combinational)
//   active_o          high while an entry is in WIDTH
//
// Register map: 0 CTRL/STATUS, 1 MODE, 2/3 DELAY lo/hi, 4/5 WIDTH lo/hi, 6 PUSH,
//               7 COUNT (ro), 8 REPEAT.
module glitch_seq_wb #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] dat_i,
   input  logic [3:0] adr_i,
   output logic [7:0] dat_o,
   input  logic       stb_i,
   input  logic       we_i,
   output logic       ack_o,
   input  logic       clk_in,
   input  logic       clk_gl,
`ifdef GLITCH_SEQ_TRIG_EN
   input  logic       trig_i,
`endif
   output logic       clk_out,
   output logic       active_o
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned CNTR_W = IDX_W + 1;   // entry count spans 0..DEPTH

   typedef struct packed {
      logic [2:0]       mode;
      logic [CNT_W-1:0] delay;
      logic [CNT_W-1:0] width;
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_LOAD  = 3'd2,
      S_DELAY = 3'd3,
      S_WIDTH = 3'd4
   } state_t;

   // Register file
   logic [2:0]        stg_mode_r;
   logic [15:0]       stg_delay_r;
   logic [15:0]       stg_width_r;
   logic [7:0]        rep_r;
   logic [CNTR_W-1:0] count_r;
   logic              ovf_r;
   entry_t            tbl [DEPTH];

   // Sequencer
   state_t            state_r, state_nxt;
   logic [IDX_W-1:0]  idx_r, idx_nxt;
   logic [7:0]        pass_r, pass_nxt;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt;
   logic              adv;

   // Decode
   logic              wr_c, wr_ctrl, start_req, abort_req, clear_req, push_req, push_ok;
   logic              idle, full, empty, armed, last_c, trig_rise;
   logic [7:0]        rd_data;
   entry_t            cur, push_entry;

   assign wr_c      = stb_i & we_i;
   assign wr_ctrl   = wr_c && (adr_i == 4'h0);
   // abort and clear both take priority over start
   assign start_req = wr_ctrl & dat_i[0] & ~dat_i[1] & ~dat_i[2];
   assign abort_req = wr_ctrl & dat_i[1];
   assign clear_req = wr_ctrl & dat_i[2];
   assign push_req  = wr_c && (adr_i == 4'h6);

   assign idle    = (state_r == S_IDLE);
   assign full    = (count_r == CNTR_W'(DEPTH));
   assign empty   = (count_r == '0);
   assign push_ok = push_req & idle & ~full;
   assign cur     = tbl[idx_r];
   assign last_c  = ((CNTR_W'(idx_r) + CNTR_W'(1)) == count_r);

   always_comb begin
      push_entry       = '0;
      push_entry.mode  = stg_mode_r;
      push_entry.delay = CNT_W'(stg_delay_r);
      push_entry.width = CNT_W'(stg_width_r);
   end

`ifdef GLITCH_SEQ_TRIG_EN
   // Two-flop synchroniser plus an edge-detect stage
   logic [2:0] trig_sync_r;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) trig_sync_r <= '0;
      else        trig_sync_r <= {trig_sync_r[1:0], trig_i};
   end
   assign trig_rise = trig_sync_r[1] & ~trig_sync_r[2];
   assign armed     = (state_r == S_ARMED);
`else
   assign trig_rise = 1'b0;
   assign armed     = 1'b0;
`endif

   // Read mux; hi staging bytes stay zero when CNT_W is 8
   always_comb begin
      rd_data = 8'h00;
      case (adr_i)
         4'h0: rd_data = {3'b000, armed, ovf_r, empty, full, idle};
         4'h1: rd_data = {5'b00000, stg_mode_r};
         4'h2: rd_data = stg_delay_r[7:0];
         4'h3: rd_data = stg_delay_r[15:8];
         4'h4: rd_data = stg_width_r[7:0];
         4'h5: rd_data = stg_width_r[15:8];
         4'h7: rd_data = 8'(count_r);
         4'h8: rd_data = rep_r;
         default: rd_data = 8'h00;
      endcase
   end

   // Bus handshake, staging registers, table bookkeeping
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ack_o       <= 1'b0;
         dat_o       <= 8'h00;
         stg_mode_r  <= '0;
         stg_delay_r <= '0;
         stg_width_r <= '0;
         rep_r       <= '0;
         count_r     <= '0;
         ovf_r       <= 1'b0;
      end else begin
         ack_o <= stb_i;
         if (stb_i && !we_i) dat_o <= rd_data;
         if (wr_c) begin
            case (adr_i)
               4'h1: stg_mode_r <= dat_i[2:0];
               4'h2: stg_delay_r[7:0] <= dat_i;
               4'h3: if (CNT_W > 8) stg_delay_r[15:8] <= dat_i;
               4'h4: stg_width_r[7:0] <= dat_i;
               4'h5: if (CNT_W > 8) stg_width_r[15:8] <= dat_i;
               4'h8: rep_r <= dat_i;
               default: ;
            endcase
         end
         if (clear_req && idle) begin
            count_r <= '0;
            ovf_r   <= 1'b0;
         end
         // pushes while full or busy are dropped and flagged
         if (push_req) begin
            if (push_ok) count_r <= count_r + CNTR_W'(1);
            else         ovf_r   <= 1'b1;
         end
      end
   end

   // Table storage; contents are only meaningful below count_r
   always_ff @(posedge clk_i) begin
      if (push_ok) tbl[count_r[IDX_W-1:0]] <= push_entry;
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= S_IDLE;
         idx_r   <= '0;
         pass_r  <= '0;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt;
         idx_r   <= idx_nxt;
         pass_r  <= pass_nxt;
         cnt_r   <= cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_r;
      idx_nxt   = idx_r;
      pass_nxt  = pass_r;
      cnt_nxt   = cnt_r;
      adv       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start_req && !empty) begin
`ifdef GLITCH_SEQ_TRIG_EN
               state_nxt = S_ARMED;
`else
               state_nxt = S_LOAD;
`endif
               idx_nxt  = '0;
               pass_nxt = rep_r;
            end
         end
         S_ARMED: begin
            if (trig_rise) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (cur.delay != '0) begin
               state_nxt = S_DELAY;
               cnt_nxt   = cur.delay;
            end else if (cur.width != '0) begin
               state_nxt = S_WIDTH;
               cnt_nxt   = cur.width;
            end else begin
               adv = 1'b1;
            end
         end
         S_DELAY: begin
            if (cnt_r == CNT_W'(1)) begin
               if (cur.width != '0) begin
                  state_nxt = S_WIDTH;
                  cnt_nxt   = cur.width;
               end else begin
                  adv = 1'b1;
               end
            end else begin
               cnt_nxt = cnt_r - CNT_W'(1);
            end
         end
         S_WIDTH: begin
            if (cnt_r == CNT_W'(1)) adv = 1'b1;
            else                    cnt_nxt = cnt_r - CNT_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
      // next entry, then wrap for another pass, then done
      if (adv) begin
         if (!last_c) begin
            idx_nxt   = idx_r + IDX_W'(1);
            state_nxt = S_LOAD;
         end else if (pass_r != 8'd0) begin
            idx_nxt   = '0;
            pass_nxt  = pass_r - 8'd1;
            state_nxt = S_LOAD;
         end else begin
            state_nxt = S_IDLE;
         end
      end
      if (abort_req) state_nxt = S_IDLE;
   end

   // Outputs: clk_out follows clk_in except during WIDTH
   always_comb begin
      active_o = 1'b0;
      clk_out  = clk_in;
      if (state_r == S_WIDTH) begin
         active_o = 1'b1;
         case (cur.mode)
            3'd1:    clk_out = 1'b0;
            3'd2:    clk_out = 1'b1;
            3'd3:    clk_out = ~clk_in;
            3'd4:    clk_out = clk_gl;
            default: clk_out = clk_in;
         endcase
      end
   end

endmodule

// File: tb/tb_glitch_seq_wb.sv
// Testbench for glitch_seq_wb: directed scenarios plus randomized tables, checked by a
// scoreboard against a cycle-list model of the playback.
module tb_glitch_seq_wb;

   localparam int unsigned DEPTH = 8;

   logic       tb_clk = 1'b0;
   logic       rst_i;
   logic [7:0] dat_i;
   logic [3:0] adr_i;
   logic [7:0] dat_o;
   logic       stb_i;
   logic       we_i;
   logic       ack_o;
   logic       clk_in;
   logic       clk_gl;
   logic       clk_out;
   logic       active_o;
   logic       tb_trig = 1'b0;

   int checks = 0;
   int errors = 0;

   glitch_seq_wb #(.DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk_i    (tb_clk),
      .rst_i    (rst_i),
      .dat_i    (dat_i),
      .adr_i    (adr_i),
      .dat_o    (dat_o),
      .stb_i    (stb_i),
      .we_i     (we_i),
      .ack_o    (ack_o),
      .clk_in   (clk_in),
      .clk_gl   (clk_gl),
`ifdef GLITCH_SEQ_TRIG_EN
      .trig_i   (tb_trig),
`endif
      .clk_out  (clk_out),
      .active_o (active_o)
   );

   always #5 tb_clk = ~tb_clk;

   // Random levels on the target and glitch clocks, settled well before the negedge check
   always @(posedge tb_clk) begin
      #3;
      clk_in = 1'($urandom);
      clk_gl = 1'($urandom);
   end

   // Reference model state
   typedef struct {
      int mode;
      int dly;
      int wid;
   } ent_t;

   ent_t       m_tbl[$];
   bit         m_ovf;
   int         m_rep, m_mode, m_dly, m_wid;
   int         sched[$];   // one item per busy cycle: -1 outside WIDTH, else the entry mode
   logic [7:0] exp_q[$];
   int         tag_q[$];
   bit         rd_seen, wr_seen;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_clk(input int m);
      case (m)
         1:       return 0;
         2:       return 1;
         3:       return int'(!clk_in);
         4:       return int'(clk_gl);
         default: return int'(clk_in);
      endcase
   endfunction

   function automatic logic [7:0] model_read(input logic [3:0] a, input bit busy);
      logic [7:0] r;
      r = 8'h00;
      case (a)
         4'h0: r = {4'b0000, m_ovf, (m_tbl.size() == 0), (m_tbl.size() == DEPTH), !busy};
         4'h1: r = 8'(m_mode);
         4'h2: r = 8'(m_dly & 255);
         4'h3: r = 8'((m_dly >> 8) & 255);
         4'h4: r = 8'(m_wid & 255);
         4'h5: r = 8'((m_wid >> 8) & 255);
         4'h7: r = 8'(m_tbl.size());
         4'h8: r = 8'(m_rep);
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // Expected playback: per pass, per entry: one load cycle, delay cycles, width cycles
   task automatic build_sched();
      for (int p = 0; p <= m_rep; p++) begin
         foreach (m_tbl[i]) begin
            sched.push_back(-1);
            for (int k = 0; k < m_tbl[i].dly; k++) sched.push_back(-1);
            for (int k = 0; k < m_tbl[i].wid; k++) sched.push_back(m_tbl[i].mode);
         end
      end
   endtask

   // Monitor: sample bus activity at the active edge, compare on the opposite edge
   always @(posedge tb_clk) begin
      rd_seen = rst_i && stb_i && !we_i;
      wr_seen = rst_i && stb_i && we_i;
   end

   always @(negedge tb_clk) begin : monitor
      int m;
      int a;
      logic [7:0] e;
      if (rst_i) begin
         if (rd_seen || wr_seen) chk("ack_o", int'(ack_o), 1);
         if (rd_seen) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard: read returned 0x%0h with nothing expected", dat_o);
            end else begin
               e = exp_q.pop_front();
               a = tag_q.pop_front();
               chk($sformatf("read adr %0d", a), int'(dat_o), int'(e));
            end
         end
         if (sched.size() != 0) begin
            m = sched.pop_front();
            chk("active_o busy", int'(active_o), int'(m >= 0));
            chk("clk_out busy", int'(clk_out), exp_clk(m));
         end else begin
            chk("active_o idle", int'(active_o), 0);
            chk("clk_out idle", int'(clk_out), int'(clk_in));
         end
      end
   end

   // One bus cycle; entered and left 1 time unit after an active edge
   task automatic bus(input bit we, input logic [3:0] a, input logic [7:0] d);
      bit   busy;
      bit   start_ok;
      ent_t e;
      busy     = (sched.size() != 0);
      start_ok = 1'b0;
      stb_i = 1'b1;
      we_i  = we;
      adr_i = a;
      dat_i = d;
      if (!we) begin
         exp_q.push_back(model_read(a, busy));
         tag_q.push_back(int'(a));
      end else begin
         case (a)
            4'h0: begin
               start_ok = d[0] && !d[1] && !d[2] && !busy && (m_tbl.size() != 0);
               if (d[2] && !busy) begin
                  m_tbl.delete();
                  m_ovf = 1'b0;
               end
            end
            4'h1: m_mode = int'(d[2:0]);
            4'h2: m_dly  = (m_dly & 32'hff00) | int'(d);
            4'h3: m_dly  = (m_dly & 32'h00ff) | (int'(d) << 8);
            4'h4: m_wid  = (m_wid & 32'hff00) | int'(d);
            4'h5: m_wid  = (m_wid & 32'h00ff) | (int'(d) << 8);
            4'h6: begin
               if (busy || m_tbl.size() >= DEPTH) m_ovf = 1'b1;
               else begin
                  e.mode = m_mode;
                  e.dly  = m_dly;
                  e.wid  = m_wid;
                  m_tbl.push_back(e);
               end
            end
            4'h8: m_rep = int'(d);
            default: ;
         endcase
      end
      @(posedge tb_clk);
      #1;
      stb_i = 1'b0;
      we_i  = 1'b0;
      if (we && a == 4'h0) begin
         if (d[1]) sched.delete();
         if (start_ok) build_sched();
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus(1'b1, a, d);
   endtask

   task automatic rd(input logic [3:0] a);
      bus(1'b0, a, 8'h00);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge tb_clk);
         #1;
      end
   endtask

   task automatic stage(input int mode, input int dly, input int wid);
      wr(4'h1, 8'(mode));
      wr(4'h2, 8'(dly & 255));
      wr(4'h3, 8'((dly >> 8) & 255));
      wr(4'h4, 8'(wid & 255));
      wr(4'h5, 8'((wid >> 8) & 255));
   endtask

   task automatic wait_idle(input int max);
      int n;
      n = 0;
      while (sched.size() != 0 && n < max) begin
         @(posedge tb_clk);
         #1;
         n++;
      end
      if (sched.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles", max);
         sched.delete();
      end
   endtask

   task automatic model_reset();
      m_tbl.delete();
      m_ovf  = 1'b0;
      m_rep  = 0;
      m_mode = 0;
      m_dly  = 0;
      m_wid  = 0;
      sched.delete();
      exp_q.delete();
      tag_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst_i  = 1'b0;
      stb_i  = 1'b0;
      we_i   = 1'b0;
      adr_i  = 4'h0;
      dat_i  = 8'h00;
      clk_in = 1'b0;
      clk_gl = 1'b0;
      model_reset();
      repeat (3) @(posedge tb_clk);
      #2;
      chk("reset ack_o", int'(ack_o), 0);
      chk("reset dat_o", int'(dat_o), 0);
      chk("reset active_o", int'(active_o), 0);
      chk("reset clk_out", int'(clk_out), int'(clk_in));
      rst_i = 1'b1;
      idle(1);

      // Reset state
      rd(4'h0);
      rd(4'h7);
      rd(4'h8);

      // Single clkgl entry: delay 3, width 5
      stage(4, 3, 5);
      rd(4'h1);
      rd(4'h2);
      wr(4'h6, 8'h00);
      wr(4'h0, 8'h01);
      rd(4'h0);
      wait_idle(50);
      rd(4'h0);
      rd(4'h7);
      wr(4'h0, 8'h04);

      // Two entries, one repeat; second entry has zero width
      stage(0, 0, 3);
      wr(4'h6, 8'h00);
      stage(0, 2, 0);
      wr(4'h6, 8'h00);
      wr(4'h8, 8'h01);
      wr(4'h0, 8'h01);
      wait_idle(50);
      rd(4'h7);
      rd(4'h0);

      // Overflow on a full table, then clear
      wr(4'h0, 8'h04);
      wr(4'h8, 8'h00);
      stage(2, 1, 1);
      for (int i = 0; i <= DEPTH; i++) wr(4'h6, 8'h00);
      rd(4'h7);
      rd(4'h0);
      wr(4'h0, 8'h04);
      rd(4'h0);

      // Long delay aborted; push and clear while busy are refused
      stage(3, 100, 5);
      wr(4'h6, 8'h00);
      wr(4'h0, 8'h01);
      idle(3);
      wr(4'h6, 8'h00);
      wr(4'h0, 8'h04);
      rd(4'h0);
      wr(4'h0, 8'h02);
      rd(4'h0);
      rd(4'h7);
      wr(4'h0, 8'h04);
      rd(4'h0);

      // Start with an empty table is ignored
      wr(4'h0, 8'h01);
      rd(4'h0);

      // Reset in the middle of an inverted-clock WIDTH phase
      stage(3, 2, 20);
      wr(4'h6, 8'h00);
      wr(4'h0, 8'h01);
      idle(6);
      chk("pre-reset active_o", int'(active_o), 1);
      rst_i = 1'b0;
      model_reset();
      #1;
      chk("in-reset active_o", int'(active_o), 0);
      chk("in-reset clk_out", int'(clk_out), int'(clk_in));
      idle(2);
      rst_i = 1'b1;
      idle(1);
      rd(4'h7);
      rd(4'h0);

      // Randomized tables, repeats and occasional aborts
      for (int it = 0; it < 12; it++) begin
         int n;
         wr(4'h0, 8'h04);
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            stage(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 5)));
            wr(4'h6, 8'h00);
         end
         wr(4'h8, 8'($urandom_range(0, 2)));
         wr(4'h0, 8'h01);
         if ($urandom_range(0, 3) == 0) begin
            idle(int'($urandom_range(0, 5)));
            wr(4'h0, 8'h02);
         end else begin
            rd(4'h0);
         end
         wait_idle(400);
         rd(4'h0);
         rd(4'h7);
      end

      idle(3);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: %0d reads never answered", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
